pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter W, default 8, SHALL set the width of the count, high_len and low_len fields.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL be a one-cycle request to begin a pulse train.
REQ-005 count  input  W  SHALL give the number of pulses per train, sampled only on an accepted start.
REQ-006 high_len  input  W  SHALL give the cycles data is high per pulse, sampled only on an accepted start.
REQ-007 low_len  input  W  SHALL give the cycles data is low after each pulse, sampled only on an accepted start.
REQ-008 data  output  1  SHALL be the generated waveform, registered.
REQ-009 busy  output  1  SHALL be high while a train is in progress, registered.
REQ-010 done  output  1  SHALL be a one-cycle pulse when a train completes, registered.
REQ-011 err  output  1  SHALL be a one-cycle pulse when a start is rejected for a zero field, registered.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, HIGH, LOW and DONE.
REQ-013 A start SHALL be accepted only in IDLE when count, high_len and low_len are all non-zero; the three fields SHALL be latched and the state SHALL move to HIGH.
REQ-014 For a start at edge k, data SHALL be 1 for the cycles k+1 .. k+high_len, then 0 for the next low_len cycles; this pattern SHALL repeat count times.
REQ-015 A down-counter SHALL time each phase; HIGH->LOW and LOW->HIGH SHALL occur when the phase counter reaches its terminal value.
REQ-016 A pulse counter SHALL track remaining pulses; after the last LOW phase the FSM SHALL enter DONE rather than HIGH.
REQ-017 busy SHALL be 1 in HIGH and LOW and 0 in IDLE and DONE.
REQ-018 A train SHALL hold busy for exactly count*(high_len+low_len) cycles.
REQ-019 done SHALL be 1 for exactly the single DONE cycle; the FSM SHALL then return to IDLE.
REQ-020 data SHALL be 0 in IDLE, LOW and DONE.
REQ-021 A start in IDLE with any zero field SHALL be rejected: err SHALL pulse in the next cycle and the state SHALL remain IDLE.
REQ-022 A start in HIGH, LOW or DONE SHALL be ignored, without err.
REQ-023 Changes to count, high_len or low_len during a train SHALL NOT affect that train.
REQ-024 All-ones values of count, high_len and low_len SHALL be supported without counter overflow or wrap.
REQ-025 A high_len or low_len of 1 SHALL produce a single-cycle phase.

Reset
REQ-026 When rst=1 at a rising edge: state SHALL become IDLE, all counters 0, and data, busy, done and err 0.
REQ-027 rst SHALL take priority over start and over an in-progress train.
REQ-028 A reset mid-train SHALL drop data to 0 at that edge, and done SHALL NOT pulse.

Configuration
REQ-029 Macro PULSE_TRAIN_GEN_ABORT_EN, when defined, SHALL add input abort (1 bit), placed after start.
REQ-030 With the macro defined: abort=1 in HIGH or LOW SHALL force data=0 and busy=0 at the next edge, set state IDLE, and suppress done; abort in IDLE or DONE SHALL have no effect; abort SHALL take priority over start.
REQ-031 Without the macro: the abort port SHALL be absent, and a train SHALL end only by completion or by rst.

Verification
REQ-032 Start with count=3, high_len=2, low_len=1 -> data sequence 110110110, busy high for 9 cycles, done for one cycle, then IDLE.
REQ-033 Start with count=1, high_len=1, low_len=1 -> data high for 1 cycle, low for 1 cycle, done 2 cycles after the accept edge plus 1.
REQ-034 Start with high_len=0 (other fields 4) -> err for 1 cycle, data, busy and done stay 0.
REQ-035 Start during the LOW phase of a count=2, high_len=3, low_len=3 train, with the fields changed to 1 -> train finishes unchanged at 12 busy cycles.
REQ-036 rst asserted at cycle 5 of a count=4, high_len=2, low_len=2 train -> all outputs 0 at the next edge, no done; a new start is then accepted normally.
REQ-037 With PULSE_TRAIN_GEN_ABORT_EN defined: abort in the 2nd HIGH cycle of count=2, high_len=4, low_len=4 -> data=0 and busy=0 at the next edge, no done.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: produces count pulses of high_len cycles high followed by
// low_len cycles low, then a one-cycle done. data, busy, done and err are
// registered. The field values are captured when a start is accepted, so
// input changes during a train have no effect on that train.
// Optional build macro PULSE_TRAIN_GEN_ABORT_EN adds an abort input that
// cancels a train that is in progress.
//
// state | meaning
// IDLE  | waiting for start; a start with any zero field raises err
// HIGH  | data high; phase counter times the high phase
// LOW   | data low; phase counter times the low phase
// DONE  | the train has completed; done is high for this one cycle
module pulse_train_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic         abort,
`endif
  input  logic [W-1:0] count,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  output logic         data,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t       state, state_nxt;
  logic [W-1:0] phase_cnt, phase_cnt_nxt;
  logic [W-1:0] pulse_cnt, pulse_cnt_nxt;
  logic [W-1:0] high_q, high_q_nxt;
  logic [W-1:0] low_q, low_q_nxt;
  logic         reject;
  logic         abort_req;
  logic         data_nxt, busy_nxt, done_nxt, err_nxt;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // State, counters, latched fields and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      high_q    <= '0;
      low_q     <= '0;
      data      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_cnt <= phase_cnt_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      high_q    <= high_q_nxt;
      low_q     <= low_q_nxt;
      data      <= data_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next state and counter updates. Each phase counter is loaded with its
  // length minus one and the phase ends on zero, so an all-ones length never
  // needs a wider counter. The pulse counter holds the number of pulses left.
  always_comb begin
    state_nxt     = state;
    phase_cnt_nxt = phase_cnt;
    pulse_cnt_nxt = pulse_cnt;
    high_q_nxt    = high_q;
    low_q_nxt     = low_q;
    reject        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if ((count != '0) && (high_len != '0) && (low_len != '0)) begin
            state_nxt     = HIGH;
            phase_cnt_nxt = high_len - W'(1);
            pulse_cnt_nxt = count;
            high_q_nxt    = high_len;
            low_q_nxt     = low_len;
          end else begin
            reject = 1'b1;
          end
        end
      end
      HIGH: begin
        if (abort_req) begin
          state_nxt     = IDLE;
          phase_cnt_nxt = '0;
          pulse_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          state_nxt     = LOW;
          phase_cnt_nxt = low_q - W'(1);
        end else begin
          phase_cnt_nxt = phase_cnt - W'(1);
        end
      end
      LOW: begin
        if (abort_req) begin
          state_nxt     = IDLE;
          phase_cnt_nxt = '0;
          pulse_cnt_nxt = '0;
        end else if (phase_cnt == '0) begin
          if (pulse_cnt == W'(1)) begin
            state_nxt     = DONE;
            pulse_cnt_nxt = '0;
          end else begin
            state_nxt     = HIGH;
            phase_cnt_nxt = high_q - W'(1);
            pulse_cnt_nxt = pulse_cnt - W'(1);
          end
        end else begin
          phase_cnt_nxt = phase_cnt - W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe
  always_comb begin
    data_nxt = (state_nxt == HIGH);
    busy_nxt = (state_nxt == HIGH) || (state_nxt == LOW);
    done_nxt = (state_nxt == DONE);
    err_nxt  = reject;
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Testbench for pulse_train_gen: directed scenarios followed by random
// traffic, each cycle checked against a queue-based waveform model.
module tb_pulse_train_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] count, high_len, low_len;
  logic         data, busy, done, err;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic         abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int busy_run = 0;

  typedef struct packed {
    logic data;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  pulse_train_gen #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort    (abort),
`endif
    .count    (count),
    .high_len (high_len),
    .low_len  (low_len),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock: the model expands an accepted start into the whole expected
  // waveform, then each cycle pops one entry and compares all outputs.
  task automatic tick();
    exp_t e;
    logic abort_now;
    @(posedge clk);
    e = '0;
    abort_now = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort_now = abort;
`endif
    if (rst) begin
      q.delete();
    end else if (abort_now && cur.busy) begin
      q.delete();
    end else if (q.size() == 0 && !cur.done && start) begin
      if (count == 0 || high_len == 0 || low_len == 0) begin
        e.err = 1'b1;
      end else begin
        for (int p = 0; p < int'(count); p++) begin
          for (int h = 0; h < int'(high_len); h++) q.push_back(4'b1100);
          for (int l = 0; l < int'(low_len); l++)  q.push_back(4'b0100);
        end
        q.push_back(4'b0010);
      end
    end
    if (!e.err && q.size() > 0) e = q.pop_front();
    cur = e;
    #1;
    if (busy) busy_run++;
    chk("data", data, cur.data);
    chk("busy", busy, cur.busy);
    chk("done", done, cur.done);
    chk("err",  err,  cur.err);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input int c, input int h, input int l);
    count    = W'(c);
    high_len = W'(h);
    low_len  = W'(l);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    logic [8:0] bits;
    rst = 1'b1; start = 1'b0; count = '0; high_len = '0; low_len = '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort = 1'b0;
`endif
    run(2);
    rst = 1'b0;
    run(2);

    // count=3 high=2 low=1: 110110110, busy for 9 cycles, then done
    busy_run = 0;
    pulse_start(3, 2, 1);
    bits = {8'b0, data};
    for (int i = 0; i < 8; i++) begin
      tick();
      bits = {bits[7:0], data};
    end
    chk_int("seq_110110110", int'(bits), 9'b110110110);
    chk_int("busy_len_3x3", busy_run, 9);
    run(3);

    // single-cycle phases
    pulse_start(1, 1, 1);
    run(4);

    // rejected start with a zero field
    pulse_start(4, 0, 4);
    run(3);
    pulse_start(0, 2, 2);
    run(2);

    // start with new fields during LOW is ignored; train stays 12 cycles
    busy_run = 0;
    pulse_start(2, 3, 3);
    run(3);
    pulse_start(1, 1, 1);
    count = 8'd1; high_len = 8'd1; low_len = 8'd1;
    run(12);
    chk_int("busy_len_ignore_start", busy_run, 12);

    // reset in cycle 5 of a train, then a normal restart
    pulse_start(4, 2, 2);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(3);
    pulse_start(2, 1, 2);
    run(8);

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // abort in the second HIGH cycle
    pulse_start(2, 4, 4);
    run(1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(4);
    pulse_start(1, 2, 2);
    run(6);
`endif

    // all-ones fields without wrap
    busy_run = 0;
    pulse_start(1, 255, 255);
    run(512);
    chk_int("busy_len_allones_len", busy_run, 510);
    busy_run = 0;
    pulse_start(255, 1, 1);
    run(512);
    chk_int("busy_len_allones_cnt", busy_run, 510);

    // random traffic; fields change every cycle
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 150) == 0);
      count    = W'($urandom_range(0, 4));
      high_len = W'($urandom_range(0, 4));
      low_len  = W'($urandom_range(0, 4));
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      abort    = ($urandom_range(0, 40) == 0);
`endif
      tick();
    end
    start = 1'b0; rst = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    abort = 1'b0;
`endif
    run(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
